// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control sequencer.
// Holds the opcode constants, the encodings of the ALU operation, ALU
// B-operand and PC-source selects, the 4-bit FSM state encoding, and a
// helper that recognises the supported opcodes.
package mips_ctrl_pkg;

  // Supported opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // alu_op encoding
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // alu_src_b encoding
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // pc_source encoding
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    MEM_ADDR = 4'd3,
    MEM_RD   = 4'd4,
    MEM_WB   = 4'd5,
    MEM_WR   = 4'd6,
    EXEC_R   = 4'd7,
    R_WB     = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    BRANCH   = 4'd11,
    JUMP     = 4'd12,
    TRAP     = 4'd13
  } state_t;

  // True for every opcode the sequencer knows how to execute
  function automatic logic is_known_op(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_LW, OP_SW: known = 1'b1;
      default:                                       known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Wrapping count of retired instructions.
// Ports:
//   clk     in   rising-edge clock
//   arst_n  in   asynchronous active-low clear
//   en      in   increment this cycle (one retire)
//   cnt     out  CNT_W-bit count, wraps 2^CNT_W-1 -> 0 silently
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count register with asynchronous clear
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle MIPS datapath (shared memory, one
// ALU, IR/MDR/A/B/ALUOut registers). Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, driving every mux select and write enable from
// the current state, stalling on mem_ready, and counting retirements.
// Optional build macro: MCFSM_ILLEGAL_TRAP_EN -- when defined, an unknown
// opcode parks the FSM in TRAP with illegal_op=1 until reset; when not
// defined there is no illegal_op port and an unknown opcode retires as a NOP.
// Ports:
//   clk, arst_n           clock, asynchronous active-low reset
//   opcode, mem_ready, zero   IR opcode, memory handshake, ALU zero flag
//   pc_write .. pc_source datapath controls (see package encodings)
//   instr_done, instr_cnt retire pulse and CNT_W-bit retire count
//   illegal_op            trap indicator (MCFSM_ILLEGAL_TRAP_EN only)
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_2_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             instr_done,
`ifdef MCFSM_ILLEGAL_TRAP_EN
  output logic             illegal_op,
`endif
  output logic [CNT_W-1:0] instr_cnt
);

  state_t state;
  state_t next_state;

  // The branch decision is made in the datapath by gating pc_write_cond with
  // zero, so the sequencer itself never looks at the flag.
  logic unused_zero;
  assign unused_zero = zero;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = EXEC_R;
          OP_ADDI:       next_state = ADDI_EX;
          OP_BEQ:        next_state = BRANCH;
          OP_J:          next_state = JUMP;
          OP_LW, OP_SW:  next_state = MEM_ADDR;
`ifdef MCFSM_ILLEGAL_TRAP_EN
          default:       next_state = TRAP;
`else
          default:       next_state = FETCH;
`endif
        endcase
      end
      MEM_ADDR: next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   next_state = FETCH;
      MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   next_state = R_WB;
      R_WB:     next_state = FETCH;
      ADDI_EX:  next_state = ADDI_WB;
      ADDI_WB:  next_state = FETCH;
      BRANCH:   next_state = FETCH;
      JUMP:     next_state = FETCH;
`ifdef MCFSM_ILLEGAL_TRAP_EN
      TRAP:     next_state = TRAP;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Output decode: everything not named for a state stays 0
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
`ifdef MCFSM_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    case (state)
      FETCH: begin
        // IR and PC+4 are captured only on the cycle memory delivers
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = SRCB_IMM_SH;
`ifndef MCFSM_ILLEGAL_TRAP_EN
        // Unknown opcode retires here as a NOP
        instr_done = ~is_known_op(opcode);
`endif
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_2_reg  = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
`ifdef MCFSM_ILLEGAL_TRAP_EN
      TRAP: illegal_op = 1'b1;
`endif
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (instr_done),
    .cnt    (instr_cnt)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm (CNT_W=4 so counter wrap is exercised).
// For each instruction the bench writes out the expected per-cycle control
// trace from the instruction's type and the chosen memory stall lengths,
// then plays the trace cycle by cycle, comparing controls and the count.
module tb_multicycle_control_fsm;

  localparam logic [5:0] T_R = 6'h00, T_ADDI = 6'h08, T_BEQ = 6'h04;
  localparam logic [5:0] T_J = 6'h02, T_LW = 6'h23, T_SW = 6'h2B;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_2_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
  } ctl_t;

  typedef struct {
    string      nm;
    logic       ready;
    logic [5:0] op;
    ctl_t       ctl;
  } step_t;

  logic       clk = 1'b0;
  logic       arst_n, mem_ready, zero;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_2_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done;
  logic [3:0] instr_cnt;
  logic       illegal_sig;

  int n_cmp = 0;
  int n_bad = 0;
  int count_m = 0;
  step_t q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done),
`ifdef MCFSM_ILLEGAL_TRAP_EN
    .illegal_op(illegal_sig),
`endif
    .instr_cnt(instr_cnt)
  );

`ifndef MCFSM_ILLEGAL_TRAP_EN
  assign illegal_sig = 1'b0;
`endif

  function automatic ctl_t sample();
    ctl_t a;
    a = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
          mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
          pc_source, instr_done, illegal_sig};
    return a;
  endfunction

  task automatic push(input string nm, input logic r, input logic [5:0] o, input ctl_t c);
    step_t s;
    s.nm = nm; s.ready = r; s.op = o; s.ctl = c;
    q.push_back(s);
  endtask

  function automatic bit known(input logic [5:0] op);
    return (op == T_R) || (op == T_ADDI) || (op == T_BEQ) ||
           (op == T_J) || (op == T_LW) || (op == T_SW);
  endfunction

  // Expected trace of one instruction: fs fetch stalls, ms data-memory stalls
  task automatic plan(input logic [5:0] op, input int fs, input int ms);
    ctl_t c;
    logic [5:0] junk;
    junk = 6'($urandom);
    for (int i = 0; i < fs; i++) begin
      c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1;
      push("fetch_wait", 1'b0, junk, c);
    end
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'd1; c.ir_write = 1'b1; c.pc_write = 1'b1;
    push("fetch_ready", 1'b1, junk, c);
    c = '0; c.alu_src_b = 2'd3;
`ifndef MCFSM_ILLEGAL_TRAP_EN
    c.instr_done = !known(op);
`endif
    push("decode", 1'($urandom), op, c);
    if (op == T_R) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'd2;
      push("r_exec", 1'($urandom), op, c);
      c = '0; c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1;
      push("r_wb", 1'($urandom), op, c);
    end else if (op == T_ADDI) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
      push("addi_exec", 1'($urandom), op, c);
      c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
      push("addi_wb", 1'($urandom), op, c);
    end else if (op == T_BEQ) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_op = 2'd1; c.pc_write_cond = 1'b1;
      c.pc_source = 2'd1; c.instr_done = 1'b1;
      push("branch", 1'($urandom), op, c);
    end else if (op == T_J) begin
      c = '0; c.pc_write = 1'b1; c.pc_source = 2'd2; c.instr_done = 1'b1;
      push("jump", 1'($urandom), op, c);
    end else if (op == T_LW || op == T_SW) begin
      c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
      push("mem_addr", 1'($urandom), op, c);
      c = '0; c.i_or_d = 1'b1;
      if (op == T_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
      for (int i = 0; i < ms; i++) push("mem_wait", 1'b0, op, c);
      if (op == T_SW) c.instr_done = 1'b1;
      push("mem_ready", 1'b1, op, c);
      if (op == T_LW) begin
        c = '0; c.reg_write = 1'b1; c.mem_2_reg = 1'b1; c.instr_done = 1'b1;
        push("lw_wb", 1'($urandom), op, c);
      end
    end else begin
`ifdef MCFSM_ILLEGAL_TRAP_EN
      c = '0; c.illegal_op = 1'b1;
      for (int i = 0; i < 6; i++) push("trap", 1'($urandom), op, c);
`endif
    end
  endtask

  // Play up to n queued steps (all if n < 0), checking every cycle
  task automatic run_queue(input int n);
    step_t s;
    ctl_t a;
    logic [3:0] ec;
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      k++;
      @(negedge clk);
      mem_ready = s.ready;
      opcode = s.op;
      zero = 1'($urandom);
      #1;
      a = sample();
      ec = 4'(count_m);
      n_cmp++;
      if ({a, instr_cnt} !== {s.ctl, ec}) begin
        n_bad++;
        $display("FAIL %s: got ctl=%h cnt=%0d, expected ctl=%h cnt=%0d",
                 s.nm, a, instr_cnt, s.ctl, ec);
      end
      if (s.ctl.instr_done) count_m++;
    end
  endtask

  task automatic test_reset();
    ctl_t a;
    arst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 6'h00;
    count_m = 0;
    q.delete();
    repeat (2) @(negedge clk);
    #1;
    a = sample();
    n_cmp++;
    if ({a, instr_cnt} !== {18'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_hold: got ctl=%h cnt=%0d, expected all 0", a, instr_cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    a = sample();
    n_cmp++;
    if ({a, instr_cnt} !== {18'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL idle: got ctl=%h cnt=%0d, expected all 0", a, instr_cnt);
    end
  endtask

  task automatic test_directed();
    plan(T_R, 0, 0);
    plan(T_LW, 0, 3);
    plan(T_SW, 2, 0);
    plan(T_BEQ, 0, 0);
    plan(T_BEQ, 1, 0);
    plan(T_J, 0, 0);
    plan(T_ADDI, 0, 0);
    plan(T_SW, 0, 2);
    run_queue(-1);
  endtask

  // 16 retirements from a known start must land back on the same count
  task automatic test_wrap();
    int start;
    start = count_m;
    for (int i = 0; i < 16; i++) plan((i % 2 == 0) ? T_J : T_R, 0, 0);
    run_queue(-1);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (instr_cnt !== 4'(start)) begin
      n_bad++;
      $display("FAIL wrap: got cnt=%0d, expected %0d", instr_cnt, 4'(start));
    end
    q.delete();
    plan(T_R, 1, 0);
    q.pop_front();
    run_queue(-1);
  endtask

  task automatic test_random();
    logic [5:0] pool[6] = '{T_R, T_ADDI, T_BEQ, T_J, T_LW, T_SW};
    logic [5:0] op;
    for (int i = 0; i < 120; i++) begin
      op = pool[$urandom_range(0, 5)];
`ifndef MCFSM_ILLEGAL_TRAP_EN
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (known(op)) op = 6'($urandom);
      end
`endif
      plan(op, $urandom_range(0, 3), $urandom_range(0, 4));
      run_queue(-1);
    end
  endtask

  // Reset asserted while a load waits on memory
  task automatic test_reset_mid();
    ctl_t a;
    plan(T_LW, 0, 6);
    run_queue(5);
    q.delete();
    #2;
    arst_n = 1'b0;
    count_m = 0;
    #1;
    a = sample();
    n_cmp++;
    if ({a, instr_cnt} !== {18'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got ctl=%h cnt=%0d, expected all 0", a, instr_cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    a = sample();
    n_cmp++;
    if ({a, instr_cnt} !== {18'd0, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_idle: got ctl=%h cnt=%0d, expected all 0", a, instr_cnt);
    end
    plan(T_ADDI, 1, 0);
    run_queue(-1);
  endtask

  task automatic test_illegal();
    plan(6'h3F, 0, 0);
    plan(T_R, 0, 0);
`ifdef MCFSM_ILLEGAL_TRAP_EN
    // TRAP is sticky, so the following R-type never starts
    q = q[0:7];
`endif
    run_queue(-1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wrap();
    test_random();
    test_reset_mid();
    test_illegal();
    test_reset();
    plan(T_J, 0, 0);
    run_queue(-1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
